// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared MIPS32 control-word layout and register constants
package id_ex_stage_pkg;

  localparam int CTRL_W          = 10;
  localparam int CTRL_REG_WRITE  = 9;
  localparam int CTRL_MEM_READ   = 8;
  localparam int CTRL_MEM_WRITE  = 7;
  localparam int CTRL_MEM_TO_REG = 6;
  localparam int CTRL_ALU_SRC    = 5;
  localparam int CTRL_REG_DST    = 4;
  localparam int CTRL_ALUOP      = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Field width of alu_op in the default packing; mem_read sits this far above it.
  localparam int CTRL_ALUOP_W = CTRL_REG_DST - CTRL_ALUOP;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard term for the ID/EX stage
module load_use_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  logic rt_nonzero;
  logic rs_match;
  logic rt_match;

  // $0 is hardwired to zero, so a load into it never produces a dependency.
  assign rt_nonzero = (ex_rt != REG_W'(REG_ZERO));
  assign rs_match   = (ex_rt == id_rs);
  assign rt_match   = id_uses_rt && (ex_rt == id_rt);

  assign hazard = ex_valid && ex_mem_read && rt_nonzero && id_valid && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush; HAZARD_STATS_EN adds stall/flush counters
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_W-1:0]     id_rs,
  input  logic [REG_W-1:0]     id_rt,
  input  logic [REG_W-1:0]     id_rd,
  input  logic                 id_uses_rt,
  input  logic [DATA_W-1:0]    id_rs_data,
  input  logic [DATA_W-1:0]    id_rt_data,
  input  logic [DATA_W-1:0]    id_imm,
  input  logic [ALUOP_W+5:0]   id_ctrl,
  input  logic                 flush,
  output logic                 ex_valid,
  output logic [REG_W-1:0]     ex_rs,
  output logic [REG_W-1:0]     ex_rt,
  output logic [REG_W-1:0]     ex_rd,
  output logic [DATA_W-1:0]    ex_rs_data,
  output logic [DATA_W-1:0]    ex_rt_data,
  output logic [DATA_W-1:0]    ex_imm,
  output logic [ALUOP_W+5:0]   ex_ctrl,
  output logic                 pc_write,
  output logic                 if_id_write
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  // Control bits above alu_op keep their positions relative to the alu_op field width.
  localparam int MEM_READ_BIT = CTRL_MEM_READ - CTRL_ALUOP_W + ALUOP_W;
  localparam int CW           = ALUOP_W + 6;

  logic hazard;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[MEM_READ_BIT]),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .hazard      (hazard)
  );

  // A flush must let the fetch redirect land even while a stall is pending.
  assign pc_write    = !hazard || flush;
  assign if_id_write = !hazard || flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      if (hazard) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : CW'(0);
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard && !flush && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage (stats checks when HAZARD_STATS_EN is defined)
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic        v;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [9:0]  ctrl;
  } exp_t;

  localparam logic [9:0] CTRL_LW  = 10'h362;
  localparam logic [9:0] CTRL_ADD = 10'h212;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [9:0]  id_ctrl;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [9:0]  ex_ctrl;
  logic        pc_write, if_id_write;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];
  exp_t m_st;
  logic m_init = 1'b0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_uses_rt  (id_uses_rt),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .id_imm      (id_imm),
    .id_ctrl     (id_ctrl),
    .flush       (flush),
    .ex_valid    (ex_valid),
    .ex_rs       (ex_rs),
    .ex_rt       (ex_rt),
    .ex_rd       (ex_rd),
    .ex_rs_data  (ex_rs_data),
    .ex_rt_data  (ex_rt_data),
    .ex_imm      (ex_imm),
    .ex_ctrl     (ex_ctrl),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One ID cycle: drive, check the stall outputs, predict the EX state, then compare after the edge.
  task automatic step(input logic rst, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic ur, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [9:0] ctrl, input logic fl, input string tag);
    logic exp_haz;
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n = rst; id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
    id_rs_data = a; id_rt_data = b; id_imm = imm; id_ctrl = ctrl; flush = fl;
    #1;
    exp_haz = m_st.v && m_st.ctrl[CTRL_MEM_READ] && (m_st.rt != 5'd0) && v &&
              ((m_st.rt == rs) || (ur && m_st.rt == rt));
    if (m_init) begin
      check({tag, ".pc_write"}, 64'(pc_write), 64'(!exp_haz || fl));
      check({tag, ".if_id_write"}, 64'(if_id_write), 64'(!exp_haz || fl));
    end
    e = '0;
    if (rst && !fl) begin
      e.rs = rs; e.rt = rt; e.rd = rd; e.a = a; e.b = b; e.imm = imm;
      e.v = v && !exp_haz;
      e.ctrl = (v && !exp_haz) ? ctrl : 10'd0;
    end
    if (!rst) begin
      m_stalls = '0;
      m_flushes = '0;
    end else begin
      if (exp_haz && !fl && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (fl && m_flushes != 32'hFFFF_FFFF) m_flushes++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check({tag, ".ex_valid"}, 64'(ex_valid), 64'(got.v));
    check({tag, ".ex_rs"}, 64'(ex_rs), 64'(got.rs));
    check({tag, ".ex_rt"}, 64'(ex_rt), 64'(got.rt));
    check({tag, ".ex_rd"}, 64'(ex_rd), 64'(got.rd));
    check({tag, ".ex_rs_data"}, 64'(ex_rs_data), 64'(got.a));
    check({tag, ".ex_rt_data"}, 64'(ex_rt_data), 64'(got.b));
    check({tag, ".ex_imm"}, 64'(ex_imm), 64'(got.imm));
    check({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(got.ctrl));
    m_st = got;
    m_init = 1'b1;
  endtask

  task automatic do_lw(input logic [4:0] rt, input string tag);
    step(1'b1, 1'b1, 5'd29, rt, 5'd0, 1'b0, 32'h1000_0000, 32'h0, 32'h10, CTRL_LW, 1'b0, tag);
  endtask

  task automatic do_add(input logic [4:0] rs, input logic [4:0] rt, input logic ur, input logic fl,
                        input string tag);
    step(1'b1, 1'b1, rs, rt, 5'd12, ur, 32'h0000_1234, 32'h0000_0042, 32'h0, CTRL_ADD, fl, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
         $urandom, $urandom, $urandom, 10'($urandom), 1'($urandom), tag);
  endtask

  initial begin
    m_st = '0;
    do_reset("reset0");
    do_reset("reset1");

    step(1'b1, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 32'hA5A5_0001, 32'h0000_00FF, 32'h0000_0007,
         10'h201, 1'b0, "pass");

    do_lw(5'd8, "lu.lw");
    do_add(5'd8, 5'd9, 1'b1, 1'b0, "lu.stall");
    do_add(5'd8, 5'd9, 1'b1, 1'b0, "lu.adv");

    do_lw(5'd0, "z.lw");
    do_add(5'd0, 5'd0, 1'b1, 1'b0, "z.use");
    do_lw(5'd8, "nrt.lw");
    do_add(5'd1, 5'd8, 1'b0, 1'b0, "nrt.use");
    do_lw(5'd8, "rt.lw");
    do_add(5'd1, 5'd8, 1'b1, 1'b0, "rt.stall");
    do_add(5'd1, 5'd8, 1'b1, 1'b0, "rt.adv");

    do_lw(5'd8, "fl.lw");
    do_add(5'd8, 5'd9, 1'b1, 1'b1, "fl.both");

    do_lw(5'd8, "b2b.lw1");
    step(1'b1, 1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 32'h4, 32'h0, 32'h8, CTRL_LW, 1'b0, "b2b.stall1");
    step(1'b1, 1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 32'h4, 32'h0, 32'h8, CTRL_LW, 1'b0, "b2b.lw2");
    do_add(5'd9, 5'd3, 1'b1, 1'b0, "b2b.stall2");
    do_add(5'd9, 5'd3, 1'b1, 1'b0, "b2b.adv");

    do_lw(5'd8, "inv.lw");
    step(1'b1, 1'b0, 5'd8, 5'd8, 5'd2, 1'b1, 32'h5, 32'h6, 32'h7, CTRL_ADD, 1'b0, "inv.use");

    do_lw(5'd8, "rst.lw");
    step(1'b0, 1'b1, 5'd8, 5'd9, 5'd12, 1'b1, 32'h1, 32'h2, 32'h3, CTRL_ADD, 1'b0, "rst.mid");
    do_add(5'd8, 5'd9, 1'b1, 1'b0, "rst.after");

`ifdef HAZARD_STATS_EN
    do_reset("st.reset");
    for (int i = 0; i < 3; i++) begin
      do_lw(5'(8 + i), "st.lw");
      do_add(5'(8 + i), 5'd1, 1'b1, 1'b0, "st.stall");
      do_add(5'(8 + i), 5'd1, 1'b1, 1'b0, "st.adv");
    end
    do_add(5'd1, 5'd2, 1'b1, 1'b1, "st.flush1");
    do_add(5'd1, 5'd2, 1'b1, 1'b1, "st.flush2");
    #1;
    check("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
    check("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_stalls = 32'hFFFF_FFFF;
    do_lw(5'd8, "sat.lw");
    do_add(5'd8, 5'd1, 1'b1, 1'b0, "sat.stall");
    #1;
    check("stall_cnt.sat", 64'(stall_cnt), 64'(m_stalls));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
